// File: rtl/clock_pkg.sv
// Shared BCD types, limits and increment helpers for the clock time counter.
package clock_pkg;
  typedef logic [7:0] bcd8_t;

  localparam bcd8_t BCD59 = 8'h59;
  localparam bcd8_t BCD23 = 8'h23;
  localparam bcd8_t BCD12 = 8'h12;
  localparam bcd8_t BCD11 = 8'h11;

  // Next value of a 00..lim BCD pair; the limit and any invalid code go to 00.
  function automatic bcd8_t bcd_next(bcd8_t v, bcd8_t lim);
    if (v[3:0] > 4'd9 || v >= lim) return 8'h00;
    if (v[3:0] == 4'd9)            return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 12 h sequence 12,01..11,12. 00 is not a legal 12 h code, so invalid
  // codes land on 12 instead of 00 to keep the counter from sticking.
  function automatic bcd8_t hour12_next(bcd8_t v);
    if (v == BCD12)                                   return 8'h01;
    if (v[3:0] > 4'd9 || v > BCD12 || v == 8'h00)    return BCD12;
    if (v[3:0] == 4'd9)                               return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/bcd_mod60.sv
// Mod-60 BCD counter with synchronous clear; used for seconds and minutes.
module bcd_mod60
  import clock_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  clr,
  output bcd8_t q,
  output logic  carry
);
  assign carry = inc && (q == BCD59);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= 8'h00;
    else if (clr) q <= 8'h00;
    else if (inc) q <= bcd_next(q, BCD59);
  end
endmodule

// File: rtl/clock_time_counter.sv
// Prescaler, 2 Hz / 1 Hz generation and BCD h:m:s timekeeping.
// Define CLOCK_HOUR12_EN for 12 h counting with a PM flag.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  secclr,
  input  logic  mininc,
  input  logic  hourinc,
  output logic  sig2hz,
  output logic  tick1hz,
  output bcd8_t sec_bcd,
  output bcd8_t min_bcd,
  output bcd8_t hour_bcd,
  output logic  pm
);
  localparam int DIV_MAX = CLK_HZ / 4 - 1;
  localparam int DIV_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  logic [DIV_W-1:0] div;
  logic [1:0]       q;
  logic             div_last, wrap, sec_inc;
  logic             sec_carry, min_carry, hour_carry, min_inc, hour_inc;

  assign div_last = (div == DIV_W'(DIV_MAX));
  assign wrap     = div_last && (q == 2'd3);
  // secclr restarts the second, so a coincident wrap is discarded entirely
  assign sec_inc  = wrap && !secclr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      q       <= '0;
      sig2hz  <= 1'b0;
      tick1hz <= 1'b0;
    end else begin
      sig2hz  <= q[0];
      tick1hz <= sec_inc;
      if (secclr) begin
        div <= '0;
        q   <= '0;
      end else if (div_last) begin
        div <= '0;
        q   <= q + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  bcd_mod60 u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .clr   (secclr),
    .q     (sec_bcd),
    .carry (sec_carry)
  );

  assign min_inc = mininc || sec_carry;

  bcd_mod60 u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .clr   (1'b0),
    .q     (min_bcd),
    .carry (min_carry)
  );

  // only a carry-driven minute rollover reaches the hours
  assign hour_carry = sec_carry && min_carry;
  assign hour_inc   = hourinc || hour_carry;

`ifdef CLOCK_HOUR12_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_bcd <= BCD12;
      pm       <= 1'b0;
    end else if (hour_inc) begin
      hour_bcd <= hour12_next(hour_bcd);
      if (hour_bcd == BCD11) pm <= ~pm;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          hour_bcd <= 8'h00;
    else if (hour_inc) hour_bcd <= bcd_next(hour_bcd, BCD23);
  end

  assign pm = 1'b0;
`endif
endmodule
